// File: rtl/iris_axil_pkg.sv
// Shared types and constants for the iris AXI-Lite initiator and its response FIFO.
package iris_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int RSP_DATA_W = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_entry_t;

endpackage

// File: rtl/iris_rsp_fifo.sv
// First-word-fall-through FIFO holding completions until the pipeline consumes them.
module iris_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 26
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    // DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/iris_axil_master.sv
// Single-beat AXI-Lite initiator: in-order command stream in, in-order completions out,
// up to MAX_OUT transactions outstanding in one direction at a time.
module iris_axil_master
    import iris_axil_pkg::*;
#(
    parameter int DATA_WIDTH = RSP_DATA_W,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_OUT    = 2,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [3:0]            cmd_wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_write_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    output logic [DATA_WIDTH-1:0] axi_wdata_o,
    output logic [3:0]            axi_wstrb_o,
    output logic                  axi_wlast_o,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    input  logic [1:0]            axi_bresp_i,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i
);

    localparam int FC_W = $clog2(RSP_DEPTH) + 1;

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  wlast_q, wlast_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            out_cnt_q, out_cnt_d;
    logic                  dir_q, dir_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;

    logic                  cmd_accept, b_hs, r_hs, push, pop;
    logic [FC_W-1:0]       fifo_cnt, fifo_cnt_next;
    logic                  fifo_full, fifo_empty;
    rsp_entry_t            push_entry, head_entry;

    // Direction may only change once every outstanding beat has completed, keeping completions in order.
    assign cmd_ready_o = rst_n && (state_q == S_IDLE) && (out_cnt_q < 2'(MAX_OUT))
                         && ((out_cnt_q == 2'd0) || (cmd_write_i == dir_q));
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;
    assign b_hs        = axi_bvalid_i && bready_q;
    assign r_hs        = axi_rvalid_i && rready_q;
    assign push        = b_hs || r_hs;
    assign pop         = rsp_valid_o && rsp_ready_i;

    always_comb begin
        push_entry = '0;
        if (b_hs) begin
            push_entry.write = 1'b1;
            push_entry.err   = (axi_bresp_i != RESP_OKAY);
        end else begin
            push_entry.rdata = axi_rdata_i;
            push_entry.err   = (axi_rresp_i != RESP_OKAY) || !axi_rlast_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        dir_d     = dir_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    dir_d = cmd_write_i;
                    if (cmd_write_i) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        wlast_d   = 1'b1;
                        awaddr_d  = cmd_addr_i;
                        wdata_d   = cmd_wdata_i;
                        wstrb_d   = cmd_wstrb_i;
                    end else begin
                        state_d   = S_RD;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr_i;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; leave once both are gone.
                if (axi_awready_i) awvalid_d = 1'b0;
                if (axi_wready_i) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) state_d = S_IDLE;
            end
            S_RD: begin
                if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case ({cmd_accept, push})
            2'b10:   out_cnt_d = out_cnt_q + 2'd1;
            2'b01:   out_cnt_d = out_cnt_q - 2'd1;
            default: out_cnt_d = out_cnt_q;
        endcase
        fifo_cnt_next = fifo_cnt + FC_W'(push) - FC_W'(pop);
        // Ready comes from the next-cycle FIFO level, so a full FIFO never sees a push.
        bready_d = dir_d && (fifo_cnt_next < FC_W'(RSP_DEPTH)) && (out_cnt_d != 2'd0);
        rready_d = !dir_d && (fifo_cnt_next < FC_W'(RSP_DEPTH)) && (out_cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            arvalid_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            out_cnt_q <= '0;
            dir_q     <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            out_cnt_q <= out_cnt_d;
            dir_q     <= dir_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
        end
    end

    iris_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_valid_o   = !fifo_empty;
    assign rsp_write_o   = head_entry.write;
    assign rsp_rdata_o   = head_entry.rdata;
    assign rsp_err_o     = head_entry.err;

    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = awaddr_q;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wlast_o   = wlast_q;
    assign axi_bready_o  = bready_q && !fifo_full;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = araddr_q;
    assign axi_rready_o  = rready_q && !fifo_full;

endmodule

// File: tb/tb_iris_axil_master.sv
// Directed bench for iris_axil_master: a memory slave model answers the AXI side, a scoreboard
// queue holds hand-computed completions and a monitor checks each one as it leaves rsp_*.
`timescale 1ns/1ps
module tb_iris_axil_master;
    import iris_axil_pkg::*;

    localparam int DW = 24;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic [3:0]    cmd_wstrb_i = '0;
    logic          rsp_valid_o, rsp_ready_i = 1'b1, rsp_write_o, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          axi_awvalid_o, axi_awready_i = 1'b0;
    logic [AW-1:0] axi_awaddr_o;
    logic          axi_wvalid_o, axi_wready_i = 1'b0, axi_wlast_o;
    logic [DW-1:0] axi_wdata_o;
    logic [3:0]    axi_wstrb_o;
    logic          axi_bvalid_i = 1'b0, axi_bready_o;
    logic [1:0]    axi_bresp_i = 2'b00;
    logic          axi_arvalid_o, axi_arready_i = 1'b0;
    logic [AW-1:0] axi_araddr_o;
    logic          axi_rvalid_i = 1'b0, axi_rready_o, axi_rlast_i = 1'b0;
    logic [DW-1:0] axi_rdata_i = '0;
    logic [1:0]    axi_rresp_i = 2'b00;

    always #5 clk = ~clk;

    iris_axil_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i), .axi_awaddr_o(axi_awaddr_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wdata_o(axi_wdata_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i), .axi_araddr_o(axi_araddr_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o), .axi_rdata_i(axi_rdata_i),
        .axi_rresp_i(axi_rresp_i), .axi_rlast_i(axi_rlast_i)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_rsp = 0;
    rsp_entry_t exp_q[$];

    // slave model knobs
    int         aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit         b_hold = 0, r_hold = 0, force_rlast0 = 0;
    logic [1:0] force_bresp = RESP_OKAY, force_rresp = RESP_OKAY;
    int         last_aw_cycles = 0, last_w_cycles = 0, aw_unstable = 0;
    logic [DW-1:0] mem [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: each completion handshake is compared against the oldest expectation.
    initial begin
        rsp_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid_o && rsp_ready_i) begin
                n_cmp++;
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp#%0d: got write=%0b rdata=0x%06h err=%0b, required no response",
                             n_rsp, rsp_write_o, rsp_rdata_o, rsp_err_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_write_o, rsp_rdata_o, rsp_err_o} !== {e.write, e.rdata, e.err}) begin
                        n_bad++;
                        $display("FAIL rsp#%0d: got write=%0b rdata=0x%06h err=%0b, required write=%0b rdata=0x%06h err=%0b",
                                 n_rsp, rsp_write_o, rsp_rdata_o, rsp_err_o, e.write, e.rdata, e.err);
                    end else begin
                        $display("ok   rsp#%0d write=%0b rdata=0x%06h err=%0b", n_rsp, e.write, e.rdata, e.err);
                    end
                end
            end
        end
    end

    // Memory slave: handshakes are seen at the negedge, state and drives updated just after posedge.
    initial begin
        bit            aw_hs, w_hs, ar_hs, b_hs, r_hs, wl_s;
        int            aw_hi, w_hi, ar_hi;
        logic [AW-1:0] aw_first, ar_s, wa;
        logic [27:0]   w_s, wd;
        logic [DW-1:0] old;
        logic [AW-1:0] aw_q[$];
        logic [27:0]   wd_q[$];
        logic [1:0]    b_q[$];
        logic [26:0]   r_q[$];
        aw_hi = 0; w_hi = 0; ar_hi = 0; aw_first = '0;
        forever begin
            @(negedge clk);
            aw_hs = axi_awvalid_o && axi_awready_i;
            w_hs  = axi_wvalid_o && axi_wready_i;
            ar_hs = axi_arvalid_o && axi_arready_i;
            b_hs  = axi_bvalid_i && axi_bready_o;
            r_hs  = axi_rvalid_i && axi_rready_o;
            if (axi_awvalid_o) begin
                if (aw_hi == 0) aw_first = axi_awaddr_o;
                else if (axi_awaddr_o !== aw_first) aw_unstable++;
                aw_hi++;
            end
            if (axi_wvalid_o) w_hi++;
            if (axi_arvalid_o) ar_hi++;
            w_s  = {axi_wstrb_o, axi_wdata_o};
            wl_s = axi_wlast_o;
            ar_s = axi_araddr_o;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                aw_q.delete(); wd_q.delete(); b_q.delete(); r_q.delete();
                aw_hi = 0; w_hi = 0; ar_hi = 0;
            end else begin
                if (aw_hs) begin aw_q.push_back(aw_first); last_aw_cycles = aw_hi; aw_hi = 0; end
                if (w_hs) begin wd_q.push_back(w_s); last_w_cycles = w_hi; w_hi = 0; chk("wlast", 32'(wl_s), 32'd1); end
                if (ar_hs) begin
                    old = mem.exists(int'(ar_s)) ? mem[int'(ar_s)] : '0;
                    r_q.push_back({!force_rlast0, force_rresp, old});
                    ar_hi = 0;
                end
                if (b_hs) void'(b_q.pop_front());
                if (r_hs) void'(r_q.pop_front());
                while (aw_q.size() > 0 && wd_q.size() > 0) begin
                    wa  = aw_q.pop_front();
                    wd  = wd_q.pop_front();
                    old = mem.exists(int'(wa)) ? mem[int'(wa)] : '0;
                    for (int b = 0; b < 3; b++) if (wd[24+b]) old[b*8 +: 8] = wd[b*8 +: 8];
                    mem[int'(wa)] = old;
                    b_q.push_back(force_bresp);
                end
            end
            axi_awready_i = axi_awvalid_o && (aw_hi >= aw_delay);
            axi_wready_i  = axi_wvalid_o && (w_hi >= w_delay);
            axi_arready_i = axi_arvalid_o && (ar_hi >= ar_delay);
            axi_bvalid_i  = (b_q.size() > 0) && !b_hold;
            axi_bresp_i   = (b_q.size() > 0) ? b_q[0] : 2'b00;
            axi_rvalid_i  = (r_q.size() > 0) && !r_hold;
            {axi_rlast_i, axi_rresp_i, axi_rdata_i} = (r_q.size() > 0) ? r_q[0] : 27'd0;
        end
    end

    // Present one command and hold it until accepted; queue its expected completion when tracked.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                         input logic [DW-1:0] er, input logic ee, input bit track);
        cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d; cmd_wstrb_i = s;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                if (track) exp_q.push_back('{write: w, rdata: er, err: ee});
                @(posedge clk);
                #1;
                cmd_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++; n_bad++;
        $display("FAIL cmd_accept: got no accept for addr 0x%0h in 300 cycles, required accept", a);
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL drain: got %0d responses still pending, required 0", exp_q.size());
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running at 1ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[1] = 24'h111111;
        mem[2] = 24'h222222;
        mem[3] = 24'h333333;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 0);
        chk("rst_awvalid", 32'(axi_awvalid_o), 0);
        chk("rst_wvalid", 32'(axi_wvalid_o), 0);
        chk("rst_wlast", 32'(axi_wlast_o), 0);
        chk("rst_arvalid", 32'(axi_arvalid_o), 0);
        chk("rst_bready", 32'(axi_bready_o), 0);
        chk("rst_rready", 32'(axi_rready_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_awaddr", 32'(axi_awaddr_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single write then readback
        issue(1, 16'h0010, 24'hABCDEF, 4'b0111, 24'h0, 0, 1);
        drain();
        issue(0, 16'h0010, 24'h0, 4'b0000, 24'hABCDEF, 0, 1);
        drain();

        // two outstanding reads, third blocked until first R
        r_hold = 1;
        issue(0, 16'h0001, 24'h0, 4'b0000, 24'h111111, 0, 1);
        issue(0, 16'h0002, 24'h0, 4'b0000, 24'h222222, 0, 1);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd3_blocked_ready", 32'(cmd_ready_o), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("two_outstanding", 32'(dut.out_cnt_q), 2);
        @(posedge clk); #1;
        r_hold = 0;
        issue(0, 16'h0003, 24'h0, 4'b0000, 24'h333333, 0, 1);
        drain();

        // write then read of same address: read waits for B
        b_hold = 1;
        issue(1, 16'h0020, 24'h123456, 4'b0111, 24'h0, 0, 1);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd_after_wr_blocked", 32'(cmd_ready_o), 0);
            @(posedge clk); #1;
        end
        b_hold = 0;
        issue(0, 16'h0020, 24'h0, 4'b0000, 24'h123456, 0, 1);
        issue(1, 16'h0020, 24'hFFFFFF, 4'b0001, 24'h0, 0, 1);
        issue(0, 16'h0020, 24'h0, 4'b0000, 24'h1234FF, 0, 1);
        drain();

        // awready late by 3 cycles, wready immediate
        aw_delay = 3;
        issue(1, 16'h0030, 24'h0A0B0C, 4'b0111, 24'h0, 0, 1);
        drain();
        chk("aw_valid_cycles", 32'(last_aw_cycles), 4);
        chk("w_valid_cycles", 32'(last_w_cycles), 1);
        chk("aw_addr_unstable", 32'(aw_unstable), 0);
        aw_delay = 0;
        issue(0, 16'h0030, 24'h0, 4'b0000, 24'h0A0B0C, 0, 1);
        drain();

        // back-pressure: FIFO fills, rready drops, nothing lost
        rsp_ready_i = 1'b0;
        issue(0, 16'h0001, 24'h0, 4'b0000, 24'h111111, 0, 1);
        issue(0, 16'h0002, 24'h0, 4'b0000, 24'h222222, 0, 1);
        issue(0, 16'h0003, 24'h0, 4'b0000, 24'h333333, 0, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_rready", 32'(axi_rready_o), 0);
        chk("bp_rvalid_pending", 32'(axi_rvalid_i), 1);
        chk("bp_rsp_valid", 32'(rsp_valid_o), 1);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        drain();

        // error responses
        force_rresp = RESP_SLVERR;
        issue(0, 16'h0001, 24'h0, 4'b0000, 24'h111111, 1, 1);
        drain();
        force_rresp = RESP_OKAY;
        force_rlast0 = 1;
        issue(0, 16'h0002, 24'h0, 4'b0000, 24'h222222, 1, 1);
        drain();
        force_rlast0 = 0;
        force_bresp = RESP_SLVERR;
        issue(1, 16'h0040, 24'h000001, 4'b0111, 24'h0, 1, 1);
        drain();
        force_bresp = RESP_OKAY;

        // reset with AR pending
        ar_delay = 1000;
        issue(0, 16'h0002, 24'h0, 4'b0000, 24'h0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("arvalid_pending", 32'(axi_arvalid_o), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_arvalid", 32'(axi_arvalid_o), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("midrst_out_cnt", 32'(dut.out_cnt_q), 0);
        repeat (2) @(posedge clk);
        #1;
        ar_delay = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 16'h0003, 24'h0, 4'b0000, 24'h333333, 0, 1);
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
